flash_line_fill: RTL and testbench

Miss-refill engine between the SRAM controller and the external SPI flash. On a read miss it accepts a byte address, issues a standard SPI READ (0x03) to the flash, shifts in one SRAM line, and delivers it word by word to the SRAM write port. It is the SPI master driving the flash's cs/sck/si pins, and its output feeds the controller's line-write path.

---
 rtl/srash_pkg.sv | 17 +
 rtl/flash_line_fill_if.sv | 34 +++
 rtl/spi_shifter.sv | 68 ++++++
 rtl/flash_line_fill.sv | 170 +++++++++++++++++
 tb/tb_flash_line_fill.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/srash_pkg.sv
// Shared definitions for the SPI-flash line refill engine.
//   FLASH_CMD_READ : standard SPI READ opcode
//   SPI_CMD_BITS   : opcode plus 24-bit address, shifted out before data
//   state_e        : refill engine states
package srash_pkg;

  localparam logic [7:0]  FLASH_CMD_READ = 8'h03;
  localparam int unsigned SPI_CMD_BITS   = 32;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StData,
    StGuard
  } state_e;

endpackage

// File: rtl/flash_line_fill_if.sv
// Controller-side refill port of flash_line_fill.
//   req/req_addr                 : refill request from the SRAM controller
//   busy/done                    : transaction status
//   fill_addr/fill_we/fill_idx/
//   fill_wdata                   : line-write path into the SRAM
// master = SRAM controller, slave = refill engine.
interface flash_line_fill_if #(
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 4
);

  localparam int unsigned IdxW = $clog2(LINE_WORDS);

  logic              req;
  logic [ADDR_W-1:0] req_addr;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] fill_addr;
  logic              fill_we;
  logic [IdxW-1:0]   fill_idx;
  logic [DATA_W-1:0] fill_wdata;

  modport master (
    output req, req_addr,
    input  busy, done, fill_addr, fill_we, fill_idx, fill_wdata
  );

  modport slave (
    input  req, req_addr,
    output busy, done, fill_addr, fill_we, fill_idx, fill_wdata
  );

endinterface

// File: rtl/spi_shifter.sv
// SPI mode-0 bit engine: divides clk into SCK, flags the clk edges on which SCK
// rises or falls, shifts TX MSB first on falls and captures RX MSB first on rises.
//   clk, rst : system clock, synchronous active-high reset
//   start    : load tx_load and begin clocking (SCK starts low)
//   stop     : stop clocking after the current edge
//   tx_load  : command/address word to send
//   so       : serial data from the flash
//   sck, si  : SPI clock and master-out data
//   rise     : SCK rises at the coming clk edge (so is sampled there)
//   fall     : SCK falls at the coming clk edge (si advances there)
//   rx_next  : receive register including the bit sampled at a rise edge
module spi_shifter #(
  parameter int unsigned SCK_DIV = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TX_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [TX_W-1:0]   tx_load,
  input  logic              so,
  output logic              sck,
  output logic              si,
  output logic              rise,
  output logic              fall,
  output logic [DATA_W-1:0] rx_next
);

  localparam int unsigned DivW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

  logic              run_q;
  logic [DivW-1:0]   div_q;
  logic              sck_q;
  logic [TX_W-1:0]   tx_q;
  logic [DATA_W-1:0] rx_q;
  logic              tick;

  // One tick per SCK half-period; each tick toggles SCK.
  assign tick    = run_q && (div_q == DivW'(SCK_DIV - 1));
  assign rise    = tick && !sck_q;
  assign fall    = tick && sck_q;
  assign rx_next = {rx_q[DATA_W-2:0], so};
  assign sck     = sck_q;
  assign si      = tx_q[TX_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      div_q <= '0;
      sck_q <= 1'b0;
      tx_q  <= '0;
      rx_q  <= '0;
    end else if (start) begin
      run_q <= 1'b1;
      div_q <= '0;
      sck_q <= 1'b0;
      tx_q  <= tx_load;
    end else if (run_q) begin
      div_q <= tick ? '0 : div_q + 1'b1;
      if (tick) sck_q <= !sck_q;
      if (rise) rx_q <= rx_next;
      if (fall) tx_q <= {tx_q[TX_W-2:0], 1'b0};
      if (stop) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/flash_line_fill.sv
// Read-miss refill engine: issues SPI READ (0x03) + line-aligned address to the
// flash, shifts in one SRAM line and writes it word by word, index 0 first.
//   clk, rst    : system clock, synchronous active-high reset
//   bus         : controller-side port (req/req_addr in; busy/done/fill_* out)
//   flash_cs_n  : SPI chip select, active low
//   flash_sck   : SPI clock, mode 0
//   flash_si    : master-out data
//   flash_so    : master-in data
module flash_line_fill
  import srash_pkg::*;
#(
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned SCK_DIV    = 2,
  parameter int unsigned CS_HI      = 2
) (
  input  logic               clk,
  input  logic               rst,
  flash_line_fill_if.slave   bus,
  output logic               flash_cs_n,
  output logic               flash_sck,
  output logic               flash_si,
  input  logic               flash_so
);

  localparam int unsigned IdxW    = $clog2(LINE_WORDS);
  localparam int unsigned WbitW   = $clog2(DATA_W);
  localparam int unsigned CmdCntW = $clog2(SPI_CMD_BITS);
  localparam int unsigned GuardW  = (CS_HI > 1) ? $clog2(CS_HI) : 1;
  localparam int unsigned OffW    = $clog2(LINE_WORDS * DATA_W / 8);
  localparam logic [ADDR_W-1:0] AlignMask = {ADDR_W{1'b1}} << OffW;

  state_e              state_q, state_d;
  logic [CmdCntW-1:0]  cmd_cnt_q, cmd_cnt_d;
  logic [WbitW-1:0]    wbit_q, wbit_d;
  logic [IdxW-1:0]     word_q, word_d;
  logic [GuardW-1:0]   guard_q, guard_d;
  logic [ADDR_W-1:0]   fill_addr_q, fill_addr_d;
  logic                fill_we_q, fill_we_d;
  logic [IdxW-1:0]     fill_idx_q, fill_idx_d;
  logic [DATA_W-1:0]   fill_wdata_q, fill_wdata_d;
  logic                done_q, done_d;

  logic                start;
  logic                stop;
  logic                sck_rise;
  logic                sck_fall;
  logic [DATA_W-1:0]   rx_next;

  spi_shifter #(
    .SCK_DIV (SCK_DIV),
    .DATA_W  (DATA_W),
    .TX_W    (SPI_CMD_BITS)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .tx_load ({FLASH_CMD_READ, bus.req_addr & AlignMask}),
    .so      (flash_so),
    .sck     (flash_sck),
    .si      (flash_si),
    .rise    (sck_rise),
    .fall    (sck_fall),
    .rx_next (rx_next)
  );

  always_comb begin
    state_d      = state_q;
    cmd_cnt_d    = cmd_cnt_q;
    wbit_d       = wbit_q;
    word_d       = word_q;
    guard_d      = guard_q;
    fill_addr_d  = fill_addr_q;
    fill_we_d    = 1'b0;
    fill_idx_d   = fill_idx_q;
    fill_wdata_d = fill_wdata_q;
    done_d       = 1'b0;
    start        = 1'b0;
    stop         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          start       = 1'b1;
          fill_addr_d = bus.req_addr & AlignMask;
          fill_idx_d  = '0;
          cmd_cnt_d   = '0;
          wbit_d      = '0;
          word_d      = '0;
          state_d     = StCmd;
        end
      end
      StCmd: begin
        // Bit counters advance on SCK falls, i.e. once each bit is complete.
        if (sck_fall) begin
          if (cmd_cnt_q == CmdCntW'(SPI_CMD_BITS - 1)) state_d = StData;
          else cmd_cnt_d = cmd_cnt_q + 1'b1;
        end
      end
      StData: begin
        // The last bit of a word is sampled on this rise; write it straight out.
        if (sck_rise && wbit_q == WbitW'(DATA_W - 1)) begin
          fill_we_d    = 1'b1;
          fill_idx_d   = word_q;
          fill_wdata_d = rx_next;
        end
        if (sck_fall) begin
          if (wbit_q == WbitW'(DATA_W - 1)) begin
            wbit_d = '0;
            if (word_q == IdxW'(LINE_WORDS - 1)) begin
              stop    = 1'b1;
              guard_d = '0;
              state_d = StGuard;
            end else begin
              word_d = word_q + 1'b1;
            end
          end else begin
            wbit_d = wbit_q + 1'b1;
          end
        end
      end
      StGuard: begin
        if (guard_q == GuardW'(CS_HI - 1)) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cmd_cnt_q    <= '0;
      wbit_q       <= '0;
      word_q       <= '0;
      guard_q      <= '0;
      fill_addr_q  <= '0;
      fill_we_q    <= 1'b0;
      fill_idx_q   <= '0;
      fill_wdata_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_cnt_q    <= cmd_cnt_d;
      wbit_q       <= wbit_d;
      word_q       <= word_d;
      guard_q      <= guard_d;
      fill_addr_q  <= fill_addr_d;
      fill_we_q    <= fill_we_d;
      fill_idx_q   <= fill_idx_d;
      fill_wdata_q <= fill_wdata_d;
      done_q       <= done_d;
    end
  end

  assign flash_cs_n     = (state_q == StIdle) || (state_q == StGuard);
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = done_q;
  assign bus.fill_addr  = fill_addr_q;
  assign bus.fill_we    = fill_we_q;
  assign bus.fill_idx   = fill_idx_q;
  assign bus.fill_wdata = fill_wdata_q;

endmodule

// File: tb/tb_flash_line_fill.sv
// Bench for flash_line_fill: a default build (A) checked every cycle against a
// timing model expressed as offsets from the accept edge, plus an SCK_DIV=1,
// LINE_WORDS=2 build (B) checked with literal expectations.
module tb_flash_line_fill;

  localparam int DW      = 32;
  localparam int D_A     = 2;
  localparam int LW_A    = 4;
  localparam int CSH     = 2;
  localparam int BITS_A  = 32 + LW_A * DW;
  localparam int T_CS_A  = 2 * BITS_A * D_A;
  localparam int T_DN_A  = T_CS_A + CSH;
  localparam int LW_B    = 2;
  localparam int BITS_B  = 32 + LW_B * DW;

  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  flash_line_fill_if #(.ADDR_W(24), .DATA_W(32), .LINE_WORDS(4)) bus_a ();
  flash_line_fill_if #(.ADDR_W(24), .DATA_W(32), .LINE_WORDS(2)) bus_b ();

  logic cs_a, sck_a, si_a, so_a;
  logic cs_b, sck_b, si_b, so_b;

  flash_line_fill #(
    .ADDR_W(24), .DATA_W(32), .LINE_WORDS(4), .SCK_DIV(2), .CS_HI(2)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .flash_cs_n(cs_a), .flash_sck(sck_a), .flash_si(si_a), .flash_so(so_a)
  );

  flash_line_fill #(
    .ADDR_W(24), .DATA_W(32), .LINE_WORDS(2), .SCK_DIV(1), .CS_HI(2)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .flash_cs_n(cs_b), .flash_sck(sck_b), .flash_si(si_b), .flash_so(so_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural SPI flash models: capture 32 command bits on SCK rises, then
  // present line data MSB first, changing on SCK falls.
  logic [31:0] line_a [LW_A];
  logic [31:0] line_b [LW_B];
  logic [31:0] fa_cmd, fb_cmd;

  initial begin : flash_a
    int cnt;
    logic prev;
    logic [31:0] w;
    cnt = 0; prev = 1'b0; so_a = 1'b0;
    forever begin
      @(cs_a or sck_a);
      if (cs_a !== 1'b0) begin
        cnt = 0; so_a = 1'b0;
      end else if (sck_a === 1'b1 && prev === 1'b0) begin
        if (cnt < 32) fa_cmd = {fa_cmd[30:0], si_a};
        cnt++;
      end else if (sck_a === 1'b0 && prev === 1'b1 && cnt >= 32 && cnt < BITS_A) begin
        w = line_a[2'((cnt - 32) / 32)] << ((cnt - 32) % 32);
        so_a = w[31];
      end
      prev = sck_a;
    end
  end

  initial begin : flash_b
    int cnt;
    logic prev;
    logic [31:0] w;
    cnt = 0; prev = 1'b0; so_b = 1'b0;
    forever begin
      @(cs_b or sck_b);
      if (cs_b !== 1'b0) begin
        cnt = 0; so_b = 1'b0;
      end else if (sck_b === 1'b1 && prev === 1'b0) begin
        if (cnt < 32) fb_cmd = {fb_cmd[30:0], si_b};
        cnt++;
      end else if (sck_b === 1'b0 && prev === 1'b1 && cnt >= 32 && cnt < BITS_B) begin
        w = line_b[1'((cnt - 32) / 32)] << ((cnt - 32) % 32);
        so_b = w[31];
      end
      prev = sck_b;
    end
  end

  // Event counters and word capture, sampled mid-cycle.
  int we_cnt_a = 0, done_cnt_a = 0, cslow_a = 0, we_cnt_b = 0;
  logic [31:0] cap_a [LW_A];
  logic [31:0] cap_b [LW_B];

  initial forever begin
    @(negedge clk);
    if (bus_a.fill_we === 1'b1) begin
      we_cnt_a++;
      cap_a[bus_a.fill_idx] = bus_a.fill_wdata;
    end
    if (bus_a.done === 1'b1) done_cnt_a++;
    if (cs_a === 1'b0) cslow_a++;
    if (bus_b.fill_we === 1'b1) begin
      we_cnt_b++;
      cap_b[bus_b.fill_idx] = bus_b.fill_wdata;
    end
  end

  // Model of build A. m_k = clk edges since the accept edge; outputs are the
  // state after that edge. Inputs change #1 after posedge, so req/rst seen here
  // are what the next posedge samples.
  logic        chk_en = 1'b0;
  bit          m_act = 1'b0;
  int          m_k = 0;
  logic [23:0] m_addr = '0;
  logic [1:0]  m_idx = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_cmd = '0;

  initial begin : model_a
    logic e_busy, e_done, e_cs, e_sck, e_si, e_we;
    logic [1:0] e_widx;
    logic [31:0] sh;
    forever begin
      @(negedge clk);
      e_busy = m_act && (m_k < T_DN_A);
      e_done = m_act && (m_k == T_DN_A);
      e_cs   = !(m_act && (m_k < T_CS_A));
      e_sck  = m_act && (m_k < T_CS_A) && (((m_k / D_A) % 2) == 1);
      sh     = m_cmd << (m_k / (2 * D_A));
      e_si   = (m_act && (m_k < 64 * D_A)) ? sh[31] : 1'b0;
      e_we   = 1'b0;
      e_widx = '0;
      for (int w = 0; w < LW_A; w++) begin
        if (m_act && (m_k == (2 * (32 + (w + 1) * DW) - 1) * D_A)) begin
          e_we   = 1'b1;
          e_widx = 2'(w);
        end
      end
      if (e_we) begin
        m_idx   = e_widx;
        m_wdata = line_a[e_widx];
      end
      if (chk_en) begin
        chk("busy", 64'(bus_a.busy), 64'(e_busy));
        chk("done", 64'(bus_a.done), 64'(e_done));
        chk("cs_n", 64'(cs_a), 64'(e_cs));
        chk("sck", 64'(sck_a), 64'(e_sck));
        chk("si", 64'(si_a), 64'(e_si));
        chk("fill_we", 64'(bus_a.fill_we), 64'(e_we));
        chk("fill_idx", 64'(bus_a.fill_idx), 64'(m_idx));
        chk("fill_wdata", 64'(bus_a.fill_wdata), 64'(m_wdata));
        chk("fill_addr", 64'(bus_a.fill_addr), 64'(m_addr));
      end
      if (rst) begin
        m_act = 1'b0; m_addr = '0; m_idx = '0; m_wdata = '0;
      end else if (!m_act || m_k == T_DN_A) begin
        if (bus_a.req) begin
          m_act  = 1'b1;
          m_k    = 0;
          m_addr = bus_a.req_addr & 24'hFFFFF0;
          m_cmd  = {8'h03, m_addr};
          m_idx  = '0;
        end else begin
          m_act = 1'b0;
        end
      end else begin
        m_k++;
      end
    end
  end

  // Waits for done on A; off = edges from the accept edge to done (-1 on timeout).
  task automatic wait_done_a(input bit hold, input int inj_at, input logic [23:0] inj_addr,
                             output int off);
    off = -1;
    for (int i = 1; i <= 2000; i++) begin
      @(posedge clk); #1;
      if (i == 1 && !hold) bus_a.req = 1'b0;
      if (inj_at != 0 && i == inj_at) begin
        bus_a.req_addr = inj_addr;
        bus_a.req      = 1'b1;
      end
      if (inj_at != 0 && i == inj_at + 4) bus_a.req = 1'b0;
      if (bus_a.done === 1'b1) begin
        off = i - 1;
        break;
      end
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int off, we0, dn0, cs0, r1, r2, offb;
    logic prev;
    rst = 1'b1;
    bus_a.req = 1'b0; bus_a.req_addr = '0;
    bus_b.req = 1'b0; bus_b.req_addr = '0;
    line_a = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h0F0F0F0F};
    line_b = '{32'hCAFEF00D, 32'h13579BDF};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", 64'(cs_a), 64'd1);
    chk("rst_sck", 64'(sck_a), 64'd0);
    chk("rst_si", 64'(si_a), 64'd0);
    chk("rst_busy", 64'(bus_a.busy), 64'd0);
    chk("rst_fill_idx", 64'(bus_a.fill_idx), 64'd0);
    chk("rst_fill_wdata", 64'(bus_a.fill_wdata), 64'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // T1: single refill from 0x001234.
    we0 = we_cnt_a; dn0 = done_cnt_a; cs0 = cslow_a;
    bus_a.req_addr = 24'h001234; bus_a.req = 1'b1;
    wait_done_a(1'b0, 0, 24'h0, off);
    chk("t1_done_off", 64'(off), 64'd642);
    chk("t1_cmd", 64'(fa_cmd), 64'h03001230);
    chk("t1_fill_addr", 64'(bus_a.fill_addr), 64'h001230);
    @(posedge clk); #1;
    chk("t1_cs_low", 64'(cslow_a - cs0), 64'd640);
    chk("t1_we_n", 64'(we_cnt_a - we0), 64'd4);
    chk("t1_done_n", 64'(done_cnt_a - dn0), 64'd1);
    chk("t1_w0", 64'(cap_a[0]), 64'hDEADBEEF);
    chk("t1_w1", 64'(cap_a[1]), 64'h01234567);
    chk("t1_w2", 64'(cap_a[2]), 64'h89ABCDEF);
    chk("t1_w3", 64'(cap_a[3]), 64'h0F0F0F0F);
    chk("t1_idx_hold", 64'(bus_a.fill_idx), 64'd3);

    // T2: second request during DATA must be ignored.
    line_a = '{32'hA5A55A5A, 32'h00000000, 32'hFFFFFFFF, 32'h80000001};
    we0 = we_cnt_a; dn0 = done_cnt_a;
    bus_a.req_addr = 24'h00ABC8; bus_a.req = 1'b1;
    wait_done_a(1'b0, 300, 24'hFFFF00, off);
    chk("t2_done_off", 64'(off), 64'd642);
    chk("t2_cmd", 64'(fa_cmd), 64'h0300ABC0);
    chk("t2_fill_addr", 64'(bus_a.fill_addr), 64'h00ABC0);
    repeat (20) @(posedge clk);
    #1;
    chk("t2_done_n", 64'(done_cnt_a - dn0), 64'd1);
    chk("t2_we_n", 64'(we_cnt_a - we0), 64'd4);
    chk("t2_busy", 64'(bus_a.busy), 64'd0);
    chk("t2_w0", 64'(cap_a[0]), 64'hA5A55A5A);
    chk("t2_w3", 64'(cap_a[3]), 64'h80000001);

    // T3: req held high restarts on the edge after done.
    line_a = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h0F0F0F0F};
    dn0 = done_cnt_a; cs0 = cslow_a;
    bus_a.req_addr = 24'h000040; bus_a.req = 1'b1;
    wait_done_a(1'b1, 0, 24'h0, off);
    chk("t3_done_off", 64'(off), 64'd642);
    @(posedge clk); #1;
    chk("t3_restart_cs_n", 64'(cs_a), 64'd0);
    chk("t3_restart_busy", 64'(bus_a.busy), 64'd1);
    bus_a.req = 1'b0;
    wait_done_a(1'b0, 0, 24'h0, off);
    chk("t3_done_off2", 64'(off), 64'd641);
    @(posedge clk); #1;
    chk("t3_done_n", 64'(done_cnt_a - dn0), 64'd2);
    chk("t3_cs_low", 64'(cslow_a - cs0), 64'd1280);

    // T4: reset mid-DATA after two words.
    we0 = we_cnt_a; dn0 = done_cnt_a;
    bus_a.req_addr = 24'h000100; bus_a.req = 1'b1;
    for (int i = 1; i <= 1000; i++) begin
      @(posedge clk); #1;
      if (i == 1) bus_a.req = 1'b0;
      if (we_cnt_a - we0 >= 2) break;
    end
    chk("t4_two_words", 64'(we_cnt_a - we0), 64'd2);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t4_cs_n", 64'(cs_a), 64'd1);
    chk("t4_sck", 64'(sck_a), 64'd0);
    chk("t4_busy", 64'(bus_a.busy), 64'd0);
    chk("t4_fill_we", 64'(bus_a.fill_we), 64'd0);
    rst = 1'b0;
    repeat (700) @(posedge clk);
    #1;
    chk("t4_no_more_we", 64'(we_cnt_a - we0), 64'd2);
    chk("t4_no_done", 64'(done_cnt_a - dn0), 64'd0);

    // T5: build B, SCK_DIV=1 and two-word lines.
    bus_b.req_addr = 24'h00020F; bus_b.req = 1'b1;
    offb = -1; r1 = -1; r2 = -1; prev = 1'b0;
    for (int i = 1; i <= 1000; i++) begin
      @(posedge clk); #1;
      if (i == 1) bus_b.req = 1'b0;
      if (sck_b && !prev) begin
        if (r1 < 0) r1 = i;
        else if (r2 < 0) r2 = i;
      end
      prev = sck_b;
      if (bus_b.done === 1'b1) begin
        offb = i - 1;
        break;
      end
    end
    chk("b_first_rise", 64'(r1), 64'd2);
    chk("b_sck_period", 64'(r2 - r1), 64'd2);
    chk("b_done_off", 64'(offb), 64'd194);
    chk("b_cmd", 64'(fb_cmd), 64'h03000208);
    chk("b_fill_addr", 64'(bus_b.fill_addr), 64'h000208);
    @(posedge clk); #1;
    chk("b_we_n", 64'(we_cnt_b), 64'd2);
    chk("b_w0", 64'(cap_b[0]), 64'hCAFEF00D);
    chk("b_w1", 64'(cap_b[1]), 64'h13579BDF);
    chk("b_busy", 64'(bus_b.busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
